// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT types and helpers (sample word, log2 size, bit reversal)
package fft_pkg;
    localparam int SAMPLE_W = 16;
    localparam int DEF_SAMPLES = 8;
    localparam int LOG2_SAMPLES = $clog2(DEF_SAMPLES);
    typedef logic [SAMPLE_W-1:0] sample_t;
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nbits; i++) r[nbits-1-i] = idx[i];
        return r;
    endfunction
endpackage

// File: rtl/fft_wr_addr_gen.sv
// fft_wr_addr_gen: write pointer with wrap and bank address; FFT_FRAME_BITREV_EN bit-reverses the address
module fft_wr_addr_gen
    import fft_pkg::*;
#(
    parameter int SAMPLES = 8,
    localparam int AW = $clog2(SAMPLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] addr,
    output logic          last_sample
);
    assign last_sample = wr_ptr == AW'(SAMPLES - 1);
`ifdef FFT_FRAME_BITREV_EN
    assign addr = AW'(bitrev(32'(wr_ptr), AW));
`else
    assign addr = wr_ptr;
`endif
    always_ff @(posedge clk) begin
        if (rst) wr_ptr <= '0;
        else if (en) wr_ptr <= last_sample ? '0 : wr_ptr + 1'b1;
    end
endmodule

// File: rtl/fft_frame_collector.sv
// fft_frame_collector: ping-pong serial-to-frame collector for the FFT; FFT_FRAME_BITREV_EN stores frames bit-reversed
module fft_frame_collector
    import fft_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SAMPLES = 8,
    parameter int SEQ_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [WIDTH-1:0]           frame_data [SAMPLES-1:0],
    output logic [SEQ_W-1:0]           frame_seq,
    output logic [$clog2(SAMPLES)-1:0] in_frame_fill
);
    localparam int AW = $clog2(SAMPLES);
    logic [1:0]       full;
    logic             wr_bank, rd_bank, last_sample;
    logic [SEQ_W-1:0] seq;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] bank [2][SAMPLES];
    logic             wr_en, rd_en;
    assign in_ready    = !full[wr_bank];
    assign frame_valid = full[rd_bank];
    assign frame_seq   = seq;
    assign wr_en       = in_valid && in_ready;
    assign rd_en       = frame_valid && frame_ready;
    fft_wr_addr_gen #(.SAMPLES(SAMPLES)) u_addr (
        .clk(clk),
        .rst(rst),
        .en(wr_en),
        .wr_ptr(in_frame_fill),
        .addr(addr),
        .last_sample(last_sample)
    );
    for (genvar i = 0; i < SAMPLES; i++) begin : g_out
        assign frame_data[i] = bank[rd_bank][i];
    end
    always_ff @(posedge clk) begin
        if (wr_en) bank[wr_bank][addr] <= in_data;
    end
    // a write into wr_bank and a read from rd_bank never target the same bank
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            seq     <= '0;
        end else begin
            if (wr_en && last_sample) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (rd_en) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
                seq           <= seq + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_collector.sv
// tb_fft_frame_collector: table vectors, directed corner sequences and random traffic against a frame-queue model
module tb_fft_frame_collector;
    localparam int W = 16;
    localparam int N = 8;
    localparam int SW = 8;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          frame_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, frame_valid;
    logic [W-1:0]  frame_data [N-1:0];
    logic [SW-1:0] frame_seq;
    logic [2:0]    in_frame_fill;
    int checks = 0;
    int errors = 0;
    logic [N*W-1:0] fq[$];
    logic [W-1:0]   part[$];
    int m_seq = 0;
    int delivered = 0;
    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         er;
        logic         ev;
        logic [2:0]   ef;
    } vec_t;
    vec_t tbl[11];
    fft_frame_collector #(.WIDTH(W), .SAMPLES(N), .SEQ_W(SW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data(frame_data),
        .frame_seq(frame_seq),
        .in_frame_fill(in_frame_fill)
    );
    always #5 clk = ~clk;
    function automatic int pos(input int j);
        int r;
`ifdef FFT_FRAME_BITREV_EN
        r = 0;
        for (int b = 0; b < 3; b++) r = r | (((j >> b) & 1) << (2 - b));
`else
        r = j;
`endif
        return r;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                         output logic acc, output logic [4:0] snap, output logic [N*W-1:0] fd);
        logic rd;
        logic [N*W-1:0] f;
        int bad;
        in_valid = v;
        in_data = d;
        frame_ready = r;
        @(negedge clk);
        snap = {in_ready, frame_valid, in_frame_fill};
        for (int i = 0; i < N; i++) fd[i*W +: W] = frame_data[i];
        chk("in_ready", 32'(in_ready), 32'(fq.size() < 2));
        chk("frame_valid", 32'(frame_valid), 32'(fq.size() > 0));
        chk("in_frame_fill", 32'(in_frame_fill), 32'(part.size()));
        if (fq.size() > 0) begin
            chk("frame_seq", 32'(frame_seq), 32'(m_seq));
            f = fq[0];
            bad = -1;
            for (int j = 0; j < N; j++)
                if (bad < 0 && frame_data[pos(j)] !== f[j*W +: W]) bad = j;
            chk("frame_data", bad < 0 ? 32'(0) : 32'(frame_data[pos(bad)]),
                bad < 0 ? 32'(0) : 32'(f[bad*W +: W]));
        end
        acc = v && fq.size() < 2;
        rd = r && fq.size() > 0;
        @(posedge clk);
        #1;
        if (rd) begin
            void'(fq.pop_front());
            m_seq = (m_seq + 1) % 256;
            delivered++;
        end
        if (acc) begin
            part.push_back(d);
            if (part.size() == N) begin
                for (int j = 0; j < N; j++) f[j*W +: W] = part[j];
                fq.push_back(f);
                part.delete();
            end
        end
    endtask
    task automatic do_reset();
        in_valid = 1'b0;
        frame_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fq.delete();
        part.delete();
        m_seq = 0;
        delivered = 0;
    endtask
    initial begin
        logic acc;
        logic [4:0] snap;
        logic [N*W-1:0] fd;
        int nxt;
        int exp_order[8];
`ifdef FFT_FRAME_BITREV_EN
        exp_order = '{1, 5, 3, 7, 2, 6, 4, 8};
`else
        exp_order = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 16'(i + 1), 1'b1, 1'b1, 1'b0, 3'(i)};
        tbl[8]  = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 3'd0};
        tbl[9]  = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[10] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 3'd0};
        @(posedge clk);
        do_reset();
        chk("reset_seq", 32'(frame_seq), 32'd0);
        for (int k = 0; k < 11; k++) begin
            cycle(tbl[k].v, tbl[k].d, tbl[k].r, acc, snap, fd);
            chk("tbl_outputs", 32'(snap), 32'({tbl[k].er, tbl[k].ev, tbl[k].ef}));
            if (k == 8)
                for (int i = 0; i < N; i++) chk("tbl_order", 32'(fd[i*W +: W]), 32'(exp_order[i]));
        end
        chk("tbl_seq_after", 32'(frame_seq), 32'd1);
        do_reset();
        nxt = 1;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 16'(nxt), 1'b0, acc, snap, fd);
            if (acc) nxt++;
        end
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        chk("bp_accepted", 32'(nxt), 32'd17);
        cycle(1'b1, 16'(nxt), 1'b1, acc, snap, fd);
        chk("bp_ready_in_accept", 32'(snap[4]), 32'd0);
        chk("bp_frame0", 32'(fd[pos(7)*W +: W]), 32'd8);
        cycle(1'b1, 16'(nxt), 1'b0, acc, snap, fd);
        if (acc) nxt++;
        chk("bp_ready_rise", 32'(snap[4]), 32'd1);
        chk("bp_seq1", 32'(frame_seq), 32'd1);
        chk("bp_frame1", 32'(fd[pos(0)*W +: W]), 32'd9);
        for (int k = 0; k < 20; k++) begin
            cycle(k[0], 16'(nxt), 1'b0, acc, snap, fd);
            if (acc) nxt++;
        end
        do_reset();
        for (int k = 0; k < 81; k++) begin
            cycle(1'b1, 16'($urandom), 1'b1, acc, snap, fd);
            chk("sus_ready", 32'(snap[4]), 32'd1);
        end
        chk("sus_seq", 32'(frame_seq), 32'd10);
        do_reset();
        for (int k = 0; k < 24; k++) cycle(k % 3 == 0, 16'(16'h100 + k), 1'b0, acc, snap, fd);
        chk("gap_valid", 32'(frame_valid), 32'd1);
        cycle(1'b0, 16'h0, 1'b1, acc, snap, fd);
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 16'(16'h1f0 + k), 1'b0, acc, snap, fd);
        chk("pre_reset_fill", 32'(in_frame_fill), 32'd5);
        do_reset();
        chk("mid_reset_fill", 32'(in_frame_fill), 32'd0);
        chk("mid_reset_valid", 32'(frame_valid), 32'd0);
        for (int k = 0; k < 8; k++) cycle(1'b1, 16'(16'h200 + k), 1'b0, acc, snap, fd);
        cycle(1'b0, 16'h0, 1'b1, acc, snap, fd);
        chk("post_reset_first", 32'(fd[pos(0)*W +: W]), 32'h200);
        for (int k = 0; k < 400; k++)
            cycle(1'($urandom), 16'($urandom), $urandom_range(0, 3) != 0 ? 1'b0 : 1'b1, acc, snap, fd);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
